rr_arb_mux: RTL and testbench

- Parametrised N-channel, WIDTH-bit arbitrating multiplexer with valid/ready handshakes on every input channel and on the output.
- Successor to the fixed 32-bit 4:1 select mux. Instead of an external select, the block picks a requesting channel by fixed priority or round-robin and registers the winner.
- Sits between multiple producers (e.g. writeback/forwarding sources, memory request ports) and one shared consumer.

---
 rtl/rr_arb_mux.sv | 95 +++++++++
 tb/tb_rr_arb_mux.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/rr_arb_mux.sv
// N-channel arbitrating multiplexer: fixed-priority or round-robin selection of a
// requesting channel into a single registered valid/ready output stage.
module rr_arb_mux #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    localparam int SEL_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mode,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_sel,
    input  logic               out_ready
);

    logic                    r_vld_p1;
    logic [WIDTH-1:0]        r_data_p1;
    logic [SEL_W-1:0]        r_sel_p1;
    logic [SEL_W-1:0]        r_ptr;

    logic                    w_load;
    logic                    w_lo_found;
    logic                    w_hi_found;
    logic [SEL_W-1:0]        w_lo_idx;
    logic [SEL_W-1:0]        w_hi_idx;
    logic [SEL_W-1:0]        w_win;
    logic [SEL_W-1:0]        w_ptr_next;
    logic [N-1:0]            w_grant;
    logic [WIDTH-1:0]        w_data;

    assign w_load = !r_vld_p1 || out_ready;

    // Round-robin is the lowest requester at or above ptr, else the lowest overall.
    always_comb begin
        w_lo_found = 1'b0;
        w_hi_found = 1'b0;
        w_lo_idx   = '0;
        w_hi_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                w_lo_found = 1'b1;
                w_lo_idx   = SEL_W'(i);
            end
            if (in_valid[i] && (SEL_W'(i) >= r_ptr)) begin
                w_hi_found = 1'b1;
                w_hi_idx   = SEL_W'(i);
            end
        end
        w_win = (mode && w_hi_found) ? w_hi_idx : w_lo_idx;
    end

    always_comb begin
        w_grant = '0;
        w_data  = '0;
        for (int i = 0; i < N; i++) begin
            if (w_lo_found && (w_win == SEL_W'(i))) begin
                w_grant[i] = 1'b1;
                w_data     = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_ptr_next = (w_win == SEL_W'(N - 1)) ? '0 : w_win + SEL_W'(1);

    // rst_n gating keeps in_ready low for the whole reset window, not just after an edge.
    assign in_ready = w_grant & in_valid & {N{w_load && rst_n}};

    // ---- output register stage (p1) ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1  <= 1'b0;
            r_data_p1 <= '0;
            r_sel_p1  <= '0;
            r_ptr     <= '0;
        end else if (w_load) begin
            if (w_lo_found) begin
                r_vld_p1  <= 1'b1;
                r_data_p1 <= w_data;
                r_sel_p1  <= w_win;
                r_ptr     <= w_ptr_next;
            end else begin
                r_vld_p1  <= 1'b0;
            end
        end
    end

    assign out_valid = r_vld_p1;
    assign out_data  = r_data_p1;
    assign out_sel   = r_sel_p1;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Scoreboard bench for rr_arb_mux (N=4, WIDTH=32): directed vectors push expected
// words into a queue; a negedge monitor pops on every output handshake.
module tb_rr_arb_mux;

    logic         clk;
    logic         rst_n;
    logic         mode;
    logic [3:0]   in_valid;
    logic [127:0] in_data;
    logic [3:0]   in_ready;
    logic         out_valid;
    logic [31:0]  out_data;
    logic [1:0]   out_sel;
    logic         out_ready;

    int total = 0;
    int bad   = 0;
    logic [33:0] q[$];

    rr_arb_mux #(.WIDTH(32), .N(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode     (mode),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_sel  (out_sel),
        .out_ready(out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    // One cycle: drive inputs, check in_ready mid-cycle, optionally expect a word.
    task automatic step(input logic [3:0] v, input logic m, input logic r,
                        input logic [3:0] exp_rdy, input logic push,
                        input logic [1:0] esel, input logic [31:0] edata);
        in_valid  = v;
        mode      = m;
        out_ready = r;
        #2;
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        if (push) q.push_back({esel, edata});
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every accepted output word against the scoreboard.
    initial begin
        logic [33:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_out got sel=%0d data=%h required none", out_sel, out_data);
                end else begin
                    e = q.pop_front();
                    if ({out_sel, out_data} !== e) begin
                        bad++;
                        $display("FAIL out_word got sel=%0d data=%h required sel=%0d data=%h",
                                 out_sel, out_data, e[33:32], e[31:0]);
                    end
                end
            end
        end
    end

    localparam logic [31:0] D0 = 32'hDEADBEEF;
    localparam logic [31:0] D1 = 32'h11111111;
    localparam logic [31:0] D2 = 32'h22222222;
    localparam logic [31:0] D3 = 32'h33333333;

    initial begin
        rst_n     = 1'b0;
        mode      = 1'b0;
        in_valid  = 4'hF;
        out_ready = 1'b1;
        in_data   = {D3, D2, D1, D0};

        // Reset held: nothing granted even with every channel requesting
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("rst_in_ready", 64'(in_ready), 64'h0);
            chk("rst_out_valid", 64'(out_valid), 64'h0);
        end
        chk("rst_out_data", 64'(out_data), 64'h0);
        chk("rst_out_sel", 64'(out_sel), 64'h0);
        in_valid = 4'h0;
        rst_n    = 1'b1;
        repeat (2) step(4'h0, 1'b0, 1'b1, 4'h0, 1'b0, 2'd0, 32'h0);
        chk("idle_out_valid", 64'(out_valid), 64'h0);
        chk("idle_out_data", 64'(out_data), 64'h0);

        // Fixed priority: ch1 always beats ch3
        repeat (4) step(4'b1010, 1'b0, 1'b1, 4'b0010, 1'b1, 2'd1, D1);
        step(4'h0, 1'b0, 1'b1, 4'h0, 1'b0, 2'd0, 32'h0);

        // Grant ch3 alone to bring ptr to 0, then round-robin over all four
        step(4'b1000, 1'b0, 1'b1, 4'b1000, 1'b1, 2'd3, D3);
        for (int k = 0; k < 8; k++)
            step(4'b1111, 1'b1, 1'b1, 4'(1 << (k % 4)), 1'b1, 2'(k % 4),
                 (k % 4 == 0) ? D0 : (k % 4 == 1) ? D1 : (k % 4 == 2) ? D2 : D3);
        step(4'h0, 1'b1, 1'b1, 4'h0, 1'b0, 2'd0, 32'h0);

        // Backpressure: hold DEADBEEF for 5 cycles while ch2 waits
        step(4'b0001, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd0, D0);
        repeat (5) begin
            step(4'b0100, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 32'h0);
            chk("bp_out_valid", 64'(out_valid), 64'h1);
            chk("bp_out_data", 64'(out_data), 64'(D0));
        end
        step(4'b0100, 1'b0, 1'b1, 4'b0100, 1'b1, 2'd2, D2);
        chk("bp_nobubble_valid", 64'(out_valid), 64'h1);
        chk("bp_nobubble_sel", 64'(out_sel), 64'h2);
        step(4'h0, 1'b0, 1'b1, 4'h0, 1'b0, 2'd0, 32'h0);

        // Sparse round-robin: grant ch1 sets ptr=2, search then wraps to ch0
        step(4'b0010, 1'b0, 1'b1, 4'b0010, 1'b1, 2'd1, D1);
        step(4'b0011, 1'b1, 1'b1, 4'b0001, 1'b1, 2'd0, D0);
        step(4'b0011, 1'b1, 1'b1, 4'b0010, 1'b1, 2'd1, D1);
        step(4'h0, 1'b1, 1'b1, 4'h0, 1'b0, 2'd0, 32'h0);

        // Async reset mid-burst (ptr=2 here)
        step(4'b1111, 1'b1, 1'b1, 4'b0100, 1'b1, 2'd2, D2);
        step(4'b1111, 1'b1, 1'b1, 4'b1000, 1'b1, 2'd3, D3);
        #2;
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'h0);
        chk("arst_in_ready", 64'(in_ready), 64'h0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        step(4'b1111, 1'b1, 1'b1, 4'b0001, 1'b1, 2'd0, D0);
        step(4'b1111, 1'b1, 1'b1, 4'b0010, 1'b1, 2'd1, D1);
        step(4'h0, 1'b1, 1'b1, 4'h0, 1'b0, 2'd0, 32'h0);

        for (int w = 0; w < 20 && q.size() != 0; w++) @(posedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d_pending required=0", q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
